logic_func_checker: RTL and testbench



---
 rtl/logic_chk_pkg.sv | 10 +
 rtl/logic_func_checker_if.sv | 14 +
 rtl/logic_chk_vecgen.sv | 32 +++
 rtl/logic_func_checker.sv | 78 +++++++
 tb/tb_logic_func_checker.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/logic_chk_pkg.sv
// logic_chk_pkg: shared types and constants for logic_func_checker
// Contents: FSM state enum, vector count, golden truth table, index/counter/error widths.
package logic_chk_pkg;
  localparam int NUM_VEC = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int ERR_W = 5;
  localparam logic [NUM_VEC-1:0] TRUTH_DEFAULT = 16'h131F;
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
endpackage

// File: rtl/logic_func_checker_if.sv
// logic_func_checker_if: control, stimulus and result bundle of logic_func_checker
// Signals: start, g (host to checker); w/x/y/z, busy, done, pass, err_count,
// first_fail_idx, first_fail_valid (checker to host).
// Modports: master = host / function-under-test side, slave = checker side.
interface logic_func_checker_if;
  import logic_chk_pkg::*;
  logic start, g, w, x, y, z, busy, done, pass, first_fail_valid;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] first_fail_idx;
  modport master(output start, g,
                 input w, x, y, z, busy, done, pass, err_count, first_fail_idx, first_fail_valid);
  modport slave(input start, g,
                output w, x, y, z, busy, done, pass, err_count, first_fail_idx, first_fail_valid);
endinterface

// File: rtl/logic_chk_vecgen.sv
// logic_chk_vecgen: vector index and settle counters for logic_func_checker
// Ports: clk, rst_n (async active-low); clear restarts at vector 0; run advances the
// settle counter; stop freezes the index on the current vector; idx is the registered
// vector; strobe marks the sampling cycle; last flags vector NUM_VEC-1.
module logic_chk_vecgen import logic_chk_pkg::*; #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  input  logic             stop,
  output logic [IDX_W-1:0] idx,
  output logic             strobe,
  output logic             last
);
  logic [CNT_W-1:0] cnt;
  assign strobe = run && cnt == CNT_W'(SETTLE_CYCLES);
  assign last = idx == IDX_W'(NUM_VEC - 1);
  // idx stays on the final (or aborting) vector after a run so w/x/y/z do not move.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (clear) begin
      idx <= '0;
      cnt <= '0;
    end else if (run) begin
      cnt <= strobe ? '0 : cnt + 1'b1;
      if (strobe && !last && !stop) idx <= idx + 1'b1;
    end
endmodule

// File: rtl/logic_func_checker.sv
// logic_func_checker: walks all 16 {w,x,y,z} vectors and checks g against a golden table
// Ports: clk, rst_n (async active-low); bus (logic_func_checker_if.slave): start, g in;
// w/x/y/z stimulus, busy, done pulse, pass, err_count, first_fail_idx/valid out.
// Macro LOGIC_CHK_ABORT_EN: when defined, the first mismatch ends the run and
// w/x/y/z hold the failing vector.
module logic_func_checker import logic_chk_pkg::*; #(
  parameter int                 SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] TRUTH = TRUTH_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_func_checker_if.slave bus
);
`ifdef LOGIC_CHK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [ERR_W-1:0] err_next;
  logic strobe, last, miss, stop;
  assign miss = bus.g != TRUTH[idx];
  assign stop = ABORT && miss;
  assign err_next = bus.err_count + ERR_W'(miss);
  assign {bus.w, bus.x, bus.y, bus.z} = idx;
  logic_chk_vecgen #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_vecgen (
    .clk,
    .rst_n,
    .clear(state == IDLE && bus.start),
    .run(state == HOLD),
    .stop,
    .idx,
    .strobe,
    .last
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.err_count <= '0;
      bus.first_fail_idx <= '0;
      bus.first_fail_valid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.start) begin
            state <= HOLD;
            bus.busy <= 1'b1;
            bus.pass <= 1'b0;
            bus.err_count <= '0;
            bus.first_fail_valid <= 1'b0;
          end
        HOLD:
          if (strobe) begin
            if (miss) begin
              bus.err_count <= err_next;
              if (!bus.first_fail_valid) begin
                bus.first_fail_valid <= 1'b1;
                bus.first_fail_idx <= idx;
              end
            end
            if (last || stop) begin
              state <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= err_next == '0;
            end
          end
        DONE: begin
          state <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_logic_func_checker.sv
// tb_logic_func_checker: randomized fault-mask runs of logic_func_checker against a table model
module tb_logic_func_checker;
  localparam logic [15:0] GOLD = 16'h131F;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic_func_checker_if bus_a();
  logic_func_checker_if bus_b();
  logic_func_checker #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  logic_func_checker #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  logic [15:0] mask;
  logic [3:0] va, vb;
  int n_cmp = 0;
  int n_bad = 0;
  assign va = {bus_a.w, bus_a.x, bus_a.y, bus_a.z};
  assign vb = {bus_b.w, bus_b.x, bus_b.y, bus_b.z};
  function automatic logic fut(input logic [3:0] v);
    return ~((v[3] | v[2]) & (v[1] | v[0]) & (v[2] | v[1]));
  endfunction
  // Function under test with a per-vector fault mask flipping its answer.
  always_comb bus_a.g = fut(va) ^ mask[va];
  always_ff @(posedge clk) bus_b.g <= fut(vb);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model(input logic [15:0] m, output int err, output int first, output int td);
    err = 0;
    first = -1;
    for (int i = 0; i < 16; i++)
      if ((fut(4'(i)) ^ m[i]) != GOLD[i]) begin
        err++;
        if (first < 0) first = i;
      end
    td = 48;
`ifdef LOGIC_CHK_ABORT_EN
    if (err > 0) begin
      err = 1;
      td = (first + 1) * 3;
    end
`endif
  endtask
  function automatic logic [15:0] tie_mask(input logic v);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = fut(4'(i)) ^ v;
    return m;
  endfunction
  task automatic results(input string tag, input int e, input int f);
    chk({tag, ".busy"}, 32'(bus_a.busy), 0);
    chk({tag, ".err"}, 32'(bus_a.err_count), e);
    chk({tag, ".ffv"}, 32'(bus_a.first_fail_valid), 32'(e > 0));
    if (e > 0) chk({tag, ".ffi"}, 32'(bus_a.first_fail_idx), f);
    chk({tag, ".pass"}, 32'(bus_a.pass), 32'(e == 0));
  endtask
  task automatic run_a(input string tag, input logic [15:0] m, input bit keep);
    int e, f, td, t;
    model(m, e, f, td);
    mask = m;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) bus_a.start = 1'b0;
    chk({tag, ".busy0"}, 32'(bus_a.busy), 1);
    t = 0;
    while (!bus_a.done && t < 200) begin
      if (t < td) chk({tag, ".vec"}, 32'(va), t / 3);
      if (!keep && td > 12) bus_a.start = (t == 10);
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, ".t_done"}, t, td);
    results(tag, e, f);
`ifdef LOGIC_CHK_ABORT_EN
    if (e > 0) chk({tag, ".vec_hold"}, 32'(va), f);
`endif
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 32'(bus_a.done), 0);
    if (keep) begin
      @(posedge clk);
      #1;
      chk({tag, ".relaunch"}, 32'(bus_a.busy), 1);
      chk({tag, ".cleared"}, 32'(bus_a.err_count), 0);
      bus_a.start = 1'b0;
      t = 0;
      while (!bus_a.done && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk({tag, ".t_done2"}, t, td);
      results({tag, "2"}, e, f);
      @(posedge clk);
    end
  endtask
  initial begin
    int t;
    bit saw;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    mask = '0;
    #23;
    chk("reset", 32'({bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
                      bus_a.first_fail_idx, bus_a.first_fail_valid, va}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a("good", 16'h0000, 1'b0);
    run_a("tie1", tie_mask(1'b1), 1'b0);
    run_a("tie0", tie_mask(1'b0), 1'b0);
    run_a("hold", 16'h0480, 1'b1);
    for (int i = 0; i < 6; i++)
      run_a("rand", i < 3 ? 16'($urandom) : 16'($urandom & $urandom & $urandom), 1'b0);
    mask = 16'hFFFF;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    t = 0;
    while (va != 4'd7 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst.reach7", 32'(va), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.async", 32'({bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
                          bus_a.first_fail_idx, bus_a.first_fail_valid, va}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      saw |= bus_a.done | bus_a.busy;
    end
    chk("rst.no_done", 32'(saw), 0);
    run_a("post_rst", 16'h0000, 1'b0);
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    t = 0;
    while (!bus_b.done && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("b.t_done", t, 32);
    chk("b.pass", 32'(bus_b.pass), 1);
    chk("b.err", 32'(bus_b.err_count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
